wash_phase_timer: RTL and testbench

- Sensor and timing stage directly upstream of the washer control FSM.
- Consumes the controller's phase outputs (valve, shake_mode, turn_mode) and a raw tank-level switch.
- Produces the FSM's advance inputs: debounced full, shake-complete Time, spin-complete dry.
- Also reports a phase fault when the controller drives more than one phase output at once.

---
 rtl/wash_phase_timer.sv | 117 +++++++++++
 tb/tb_wash_phase_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Sensor/timing stage ahead of the washer controller: debounced tank level, shake/spin timers,
// sticky phase-conflict fault. Define WASH_PAUSE_EN to add a pause input that freezes the timers.
module wash_phase_timer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SHAKE_CYCLES  = 16,
  parameter int unsigned TURN_CYCLES   = 8,
  parameter int unsigned FULL_DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valve,
  input  logic             shake_mode,
  input  logic             turn_mode,
  input  logic             level_raw,
`ifdef WASH_PAUSE_EN
  input  logic             pause,
`endif
  output logic             full,
  output logic             Time,
  output logic             dry,
  output logic             fault,
  output logic [CNT_W-1:0] elapsed
);

  localparam int unsigned DebW = (FULL_DEBOUNCE < 2) ? 1 : $clog2(FULL_DEBOUNCE + 1);
  localparam logic [DebW-1:0]  DebLast    = DebW'(FULL_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] ShakeTgt   = CNT_W'(SHAKE_CYCLES);
  localparam logic [CNT_W-1:0] TurnTgt    = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] ShakeLast  = CNT_W'(SHAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TurnLast   = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {PhIdle, PhFill, PhShake, PhTurn, PhFault} phase_e;

  phase_e            phase_q, phase_d;
  logic              sync1_q, sync2_q;
  logic [DebW-1:0]   deb_q, deb_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, base;
  logic              time_q, time_d;
  logic              dry_q, dry_d;
  logic [1:0]        n_active;

  assign n_active = {1'b0, valve} + {1'b0, shake_mode} + {1'b0, turn_mode};

  always_comb begin
    if (phase_q == PhFault || n_active > 2'd1) phase_d = PhFault;
    else if (valve)                            phase_d = PhFill;
    else if (shake_mode)                       phase_d = PhShake;
    else if (turn_mode)                        phase_d = PhTurn;
    else                                       phase_d = PhIdle;
  end

  // Debounce runs against the registered full value, independent of phase.
  always_comb begin
    deb_d  = '0;
    full_d = full_q;
    if (sync2_q != full_q) begin
      if (deb_q == DebLast) full_d = ~full_q;
      else                  deb_d  = deb_q + 1'b1;
    end
  end

  // A phase change discards the count; the entry edge already counts as the first cycle.
  always_comb begin
    base   = (phase_d != phase_q) ? '0 : cnt_q;
    cnt_d  = '0;
    time_d = 1'b0;
    dry_d  = 1'b0;
    case (phase_d)
      PhShake: begin
        cnt_d  = (base < ShakeTgt) ? base + 1'b1 : base;
        time_d = (base >= ShakeLast);
      end
      PhTurn: begin
        cnt_d = (base < TurnTgt) ? base + 1'b1 : base;
        dry_d = (base >= TurnLast);
      end
      default: ;
    endcase
`ifdef WASH_PAUSE_EN
    if (pause && phase_d != PhFault) begin
      cnt_d  = cnt_q;
      time_d = time_q;
      dry_d  = dry_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PhIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      time_q  <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sync1_q <= level_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      dry_q   <= dry_d;
    end
  end

  assign full    = full_q;
  assign Time    = time_q;
  assign dry     = dry_q;
  assign fault   = (phase_q == PhFault);
  assign elapsed = cnt_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed self-checking bench for wash_phase_timer with default parameters.
module tb_wash_phase_timer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valve, shake_mode, turn_mode, level_raw;
  logic        full, Time, dry, fault;
  logic [15:0] elapsed;
`ifdef WASH_PAUSE_EN
  logic        pause;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  wash_phase_timer #(
    .CNT_W        (16),
    .SHAKE_CYCLES (16),
    .TURN_CYCLES  (8),
    .FULL_DEBOUNCE(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .valve     (valve),
    .shake_mode(shake_mode),
    .turn_mode (turn_mode),
    .level_raw (level_raw),
`ifdef WASH_PAUSE_EN
    .pause     (pause),
`endif
    .full      (full),
    .Time      (Time),
    .dry       (dry),
    .fault     (fault),
    .elapsed   (elapsed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    valve      = 1'b0;
    shake_mode = 1'b0;
    turn_mode  = 1'b0;
    level_raw  = 1'b0;
`ifdef WASH_PAUSE_EN
    pause      = 1'b0;
`endif
    #2;
    check("rst_full", full, 0);
    check("rst_time", Time, 0);
    check("rst_dry", dry, 0);
    check("rst_fault", fault, 0);
    check("rst_elapsed", elapsed, 0);
    #15;
    reset_n = 1'b1;

    // Level debounce: 2 sync + 4 debounce edges.
    level_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("full_rise", full, (i == 6) ? 1 : 0);
    end
    level_raw = 1'b0;
    repeat (3) step();
    level_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("full_glitch", full, 1);
    end

    // Shake timer with saturation.
    shake_mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("shake_elapsed", elapsed, (i < 16) ? i : 16);
      check("shake_time", Time, (i >= 16) ? 1 : 0);
      check("shake_dry", dry, 0);
    end
    shake_mode = 1'b0;
    step();
    check("shake_off_time", Time, 0);
    check("shake_off_elapsed", elapsed, 0);

    // Early drop discards the count.
    shake_mode = 1'b1;
    repeat (10) step();
    check("partial_elapsed", elapsed, 10);
    shake_mode = 1'b0;
    step();
    check("gap_elapsed", elapsed, 0);
    shake_mode = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("reentry_elapsed", elapsed, i);
      check("reentry_time", Time, (i == 16) ? 1 : 0);
    end
    shake_mode = 1'b0;
    step();

    // Spin timer.
    turn_mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("turn_elapsed", elapsed, (i < 8) ? i : 8);
      check("turn_dry", dry, (i >= 8) ? 1 : 0);
      check("turn_time", Time, 0);
    end
    turn_mode = 1'b0;
    step();
    check("turn_off_dry", dry, 0);

    // Illegal phase combination latches fault.
    valve      = 1'b1;
    shake_mode = 1'b1;
    step();
    check("fault_set", fault, 1);
    check("fault_elapsed", elapsed, 0);
    valve = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("fault_sticky", fault, 1);
      check("fault_time", Time, 0);
      check("fault_elapsed_hold", elapsed, 0);
    end
    check("fault_full_alive", full, 1);

    // Asynchronous reset mid-cycle.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_fault", fault, 0);
    check("async_full", full, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_elapsed", elapsed, 1);
    check("post_rst_fault", fault, 0);
    shake_mode = 1'b0;
    step();

`ifdef WASH_PAUSE_EN
    shake_mode = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      pause = (i >= 6 && i <= 10);
      step();
      check("pause_elapsed", elapsed, (i <= 5) ? i : (i <= 10) ? 5 : i - 5);
      check("pause_time", Time, (i == 21) ? 1 : 0);
    end
    pause      = 1'b0;
    shake_mode = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
